cfg_loader: RTL and testbench
=============================

CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 Parameter FRAME_BITS, default 18: configuration bits per block frame.
REQ-002 Parameter NUM_BLOCKS, default 77: number of block frames per full load.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 START  input  1  one-cycle load request, sampled in IDLE or DONE only.
REQ-006 HOST_DATA  input  FRAME_BITS  one frame word from host.
REQ-007 HOST_VALID  input  1  HOST_DATA valid.
REQ-008 HOST_READY  output  1  loader accepts a word this cycle.
REQ-009 MASTER_DIN  output  1  serial config bit to memory controller.
REQ-010 MASTER_EN  output  1  memory controller enable during load.
REQ-011 CH_ADDR  output  1  one-cycle pulse advancing memory controller to next block.
REQ-012 PROG_DONE  output  1  full load complete.
REQ-013 BUSY  output  1  load in progress.
REQ-014 BLOCK_CNT  output  7  index of block currently being loaded.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_WORD, SHIFT, ADVANCE, DONE.
REQ-016 IDLE: START -> WAIT_WORD; BLOCK_CNT=0; MASTER_EN, BUSY go high next cycle.
REQ-017 WAIT_WORD: HOST_READY=1; HOST_VALID&HOST_READY captures HOST_DATA into shift register -> SHIFT, bit counter=0.
REQ-018 HOST_READY SHALL be 0 in every state except WAIT_WORD; no word is accepted otherwise.
REQ-019 SHIFT: one bit per cycle, LSB first; MASTER_DIN registered, bit 0 appears the cycle after handshake.
REQ-020 SHIFT lasts exactly FRAME_BITS cycles; MASTER_DIN holds last bit until next frame starts.
REQ-021 End of SHIFT with BLOCK_CNT<NUM_BLOCKS-1 -> ADVANCE; with BLOCK_CNT==NUM_BLOCKS-1 -> DONE (no CH_ADDR after last block).
REQ-022 ADVANCE: CH_ADDR=1 for exactly one cycle, BLOCK_CNT increments, -> WAIT_WORD.
REQ-023 DONE: PROG_DONE=1 and MASTER_EN=0, BUSY=0, held until RST or START.
REQ-024 START in DONE: PROG_DONE clears, new load begins as from IDLE.
REQ-025 START while BUSY SHALL be ignored.
REQ-026 HOST_VALID low in WAIT_WORD: loader stalls indefinitely, MASTER_EN stays high, no outputs change.
REQ-027 Bit counter width SHALL be ceil(log2(FRAME_BITS+1)); BLOCK_CNT never exceeds NUM_BLOCKS-1.

Reset
REQ-028 RST SHALL force IDLE immediately, asynchronously, including mid-frame.
REQ-029 Reset values: MASTER_DIN=0, MASTER_EN=0, CH_ADDR=0, PROG_DONE=0, HOST_READY=0, BUSY=0, BLOCK_CNT=0, shift register=0.
REQ-030 A load interrupted by RST SHALL NOT resume; a new START restarts from block 0.

Configuration
REQ-031 Macro CFG_LOADER_PARITY_EN defined: adds input HOST_PAR (1, even parity over HOST_DATA) and output PAR_ERR (1).
REQ-032 With macro: parity mismatch at handshake -> DONE-like ERROR hold, PROG_DONE=0, PAR_ERR=1, MASTER_EN=0, until RST or START.
REQ-033 Without macro: HOST_PAR/PAR_ERR absent, all words accepted unchecked.

Verification
REQ-034 Full load, 77 words 0x29 4B4 (18'b101001010010110100) each, HOST_VALID always high -> 77x18 MASTER_DIN bits LSB first, 76 CH_ADDR pulses, PROG_DONE high after last bit.
REQ-035 HOST_VALID withheld 10 cycles before block 5 -> MASTER_EN stays 1, no CH_ADDR, BLOCK_CNT=5 held, stream resumes unchanged.
REQ-036 RST asserted at bit 9 of block 3 -> all outputs reset values same cycle; next START reloads from BLOCK_CNT=0.
REQ-037 START pulsed during SHIFT of block 2 -> ignored, counts and stream unaffected.
REQ-038 FRAME_BITS=4, NUM_BLOCKS=2, words 4'hA,4'h5 -> MASTER_DIN 0,1,0,1 then CH_ADDR pulse then 1,0,1,0 then PROG_DONE.
REQ-039 CFG_LOADER_PARITY_EN, block 1 with wrong HOST_PAR -> PAR_ERR=1, PROG_DONE=0, no further CH_ADDR.

Source files
------------

// File: rtl/cfg_loader.sv
// Serial configuration loader: takes frame words from a host over a valid/ready
// handshake and streams them LSB-first to a memory controller, one block at a time.
// Optional macro CFG_LOADER_PARITY_EN adds even-parity checking (host_par / par_err).
module cfg_loader #(
  parameter int FRAME_BITS = 18,
  parameter int NUM_BLOCKS = 77
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] host_data,
  input  logic                  host_valid,
  output logic                  host_ready,
  output logic                  master_din,
  output logic                  master_en,
  output logic                  ch_addr,
  output logic                  prog_done,
  output logic                  busy,
  output logic [6:0]            block_cnt
`ifdef CFG_LOADER_PARITY_EN
  ,
  input  logic                  host_par,
  output logic                  par_err
`endif
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
  localparam logic [6:0]    LAST_BLK = 7'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WORD,
    SHIFT,
    ADVANCE,
    DONE
`ifdef CFG_LOADER_PARITY_EN
    ,
    ERROR
`endif
  } state_t;

  state_t                state, state_n;
  logic [FRAME_BITS-1:0] sr;
  logic [CW-1:0]         bit_cnt;
  logic                  par_bad;
  logic                  accept;

`ifdef CFG_LOADER_PARITY_EN
  // host_par makes the total count of ones even; any other combination is corrupt.
  assign par_bad = host_par != (^host_data);
`else
  assign par_bad = 1'b0;
`endif

  assign accept = (state == WAIT_WORD) && host_valid && !par_bad;

  // NOTE: async reset sits in the sensitivity list; all state updates are
  // non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every output is given a default first so no path through the case
  // leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_n    = state;
    host_ready = 1'b0;
    master_en  = 1'b0;
    busy       = 1'b0;
    ch_addr    = 1'b0;
    prog_done  = 1'b0;
`ifdef CFG_LOADER_PARITY_EN
    par_err    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) state_n = WAIT_WORD;
      end
      WAIT_WORD: begin
        host_ready = 1'b1;
        master_en  = 1'b1;
        busy       = 1'b1;
        if (host_valid) state_n = par_bad ? DONE : SHIFT;
`ifdef CFG_LOADER_PARITY_EN
        if (host_valid && par_bad) state_n = ERROR;
`endif
      end
      SHIFT: begin
        master_en = 1'b1;
        busy      = 1'b1;
        if (bit_cnt == LAST_BIT) state_n = (block_cnt == LAST_BLK) ? DONE : ADVANCE;
      end
      ADVANCE: begin
        master_en = 1'b1;
        busy      = 1'b1;
        ch_addr   = 1'b1;
        state_n   = WAIT_WORD;
      end
      DONE: begin
        prog_done = 1'b1;
        if (start) state_n = WAIT_WORD;
      end
`ifdef CFG_LOADER_PARITY_EN
      ERROR: begin
        par_err = 1'b1;
        if (start) state_n = WAIT_WORD;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Bit 0 goes straight to master_din at the handshake, so the shifter only
  // needs to supply bits 1..FRAME_BITS-1; the last bit then holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr         <= '0;
      bit_cnt    <= '0;
      master_din <= 1'b0;
      block_cnt  <= '0;
    end else begin
      if (accept) begin
        master_din <= host_data[0];
        sr         <= host_data >> 1;
        bit_cnt    <= '0;
      end else if (state == SHIFT && bit_cnt != LAST_BIT) begin
        master_din <= sr[0];
        sr         <= sr >> 1;
        bit_cnt    <= bit_cnt + 1'b1;
      end
      if (state == ADVANCE) begin
        block_cnt <= block_cnt + 7'd1;
      end else if (start && state != WAIT_WORD && state != SHIFT) begin
        block_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench for cfg_loader: default 18x77 instance for full-load, stall,
// ignored start and mid-frame reset; a 4x2 instance for the small stream case.
module tb_cfg_loader;

  localparam int FB = 18;
  localparam int NB = 77;
  localparam logic [FB-1:0] WORD = 18'b101001010010110100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, host_valid;
  logic [FB-1:0] host_data;
  logic          host_ready, master_din, master_en, ch_addr, prog_done, busy;
  logic [6:0]    block_cnt;

  logic          s_start, s_valid;
  logic [3:0]    s_data;
  logic          s_ready, s_din, s_en, s_ch, s_done, s_busy;
  logic [6:0]    s_cnt;

`ifdef CFG_LOADER_PARITY_EN
  logic par_flip, host_par, par_err, s_par, s_perr;
  assign host_par = (^host_data) ^ par_flip;
  assign s_par    = ^s_data;
`endif

  int total = 0;
  int bad   = 0;
  int ch_cnt;
  logic cnt_clr;

  cfg_loader dut (
    .clk(clk), .rst(rst), .start(start), .host_data(host_data),
    .host_valid(host_valid), .host_ready(host_ready), .master_din(master_din),
    .master_en(master_en), .ch_addr(ch_addr), .prog_done(prog_done),
    .busy(busy), .block_cnt(block_cnt)
`ifdef CFG_LOADER_PARITY_EN
    , .host_par(host_par), .par_err(par_err)
`endif
  );

  cfg_loader #(.FRAME_BITS(4), .NUM_BLOCKS(2)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .host_data(s_data),
    .host_valid(s_valid), .host_ready(s_ready), .master_din(s_din),
    .master_en(s_en), .ch_addr(s_ch), .prog_done(s_done),
    .busy(s_busy), .block_cnt(s_cnt)
`ifdef CFG_LOADER_PARITY_EN
    , .host_par(s_par), .par_err(s_perr)
`endif
  );

  always @(posedge clk) begin
    if (cnt_clr)      ch_cnt <= 0;
    else if (ch_addr) ch_cnt <= ch_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".ready"}, host_ready, 0);
    chk({tag, ".din"},   master_din, 0);
    chk({tag, ".en"},    master_en,  0);
    chk({tag, ".ch"},    ch_addr,    0);
    chk({tag, ".done"},  prog_done,  0);
    chk({tag, ".busy"},  busy,       0);
    chk({tag, ".cnt"},   block_cnt,  0);
  endtask

  // Entry: just after a negedge with the DUT expected in WAIT_WORD for block b.
  task automatic do_block(input int b, input logic [FB-1:0] w, input int stall,
                          input int poke, input int abort);
    chk("blk.ready", host_ready, 1);
    chk("blk.cnt",   block_cnt,  b);
    chk("blk.en",    master_en,  1);
    chk("blk.busy",  busy,       1);
    chk("blk.done",  prog_done,  0);
    if (stall > 0) host_valid = 1'b0;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall.ready", host_ready, 1);
      chk("stall.en",    master_en,  1);
      chk("stall.ch",    ch_addr,    0);
      chk("stall.cnt",   block_cnt,  b);
    end
    host_data  = w;
    host_valid = 1'b1;
    @(negedge clk);
    host_data = ~w;
    for (int i = 0; i < FB; i++) begin
      chk("shift.din",   master_din, w[i]);
      chk("shift.ready", host_ready, 0);
      chk("shift.ch",    ch_addr,    0);
      chk("shift.cnt",   block_cnt,  b);
      if (i == abort) begin
        rst = 1'b1;
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (i == poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (b < NB - 1) begin
      chk("adv.ch",  ch_addr,    1);
      chk("adv.din", master_din, w[FB-1]);
      chk("adv.en",  master_en,  1);
      @(negedge clk);
    end else begin
      chk("last.done", prog_done, 1);
      chk("last.en",   master_en, 0);
      chk("last.busy", busy,      0);
      chk("last.ch",   ch_addr,   0);
    end
  endtask

  initial begin
    logic [3:0] sv;
    rst = 1'b1; start = 1'b0; host_valid = 1'b0; host_data = '0; cnt_clr = 1'b1;
    s_start = 1'b0; s_valid = 1'b0; s_data = '0;
`ifdef CFG_LOADER_PARITY_EN
    par_flip = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_reset("reset");
    chk("reset.s_busy", s_busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.busy",  busy,       0);
    chk("idle.ready", host_ready, 0);

    // Small instance: 4'hA then 4'h5 -> 0,1,0,1 | CH_ADDR | 1,0,1,0 | PROG_DONE
    s_start = 1'b1; @(negedge clk); s_start = 1'b0;
    chk("s.ready0", s_ready, 1);
    chk("s.en0",    s_en,    1);
    s_data = 4'hA; s_valid = 1'b1; @(negedge clk); s_valid = 1'b0;
    sv = 4'hA;
    for (int i = 0; i < 4; i++) begin
      chk("s.din0", s_din, sv[i]);
      chk("s.ch0",  s_ch,  0);
      @(negedge clk);
    end
    chk("s.adv", s_ch, 1);
    @(negedge clk);
    chk("s.ready1", s_ready, 1);
    chk("s.cnt1",   s_cnt,   1);
    s_data = 4'h5; s_valid = 1'b1; @(negedge clk); s_valid = 1'b0;
    sv = 4'h5;
    for (int i = 0; i < 4; i++) begin
      chk("s.din1", s_din, sv[i]);
      chk("s.ch1",  s_ch,  0);
      @(negedge clk);
    end
    chk("s.done", s_done, 1);
    chk("s.en",   s_en,   0);
    chk("s.ch2",  s_ch,   0);
`ifdef CFG_LOADER_PARITY_EN
    chk("s.perr", s_perr, 0);
`endif

    // Full load with a 10-cycle stall before block 5 and a START poke in block 2
    cnt_clr = 1'b0; host_valid = 1'b1; host_data = ~WORD;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int b = 0; b < NB; b++)
      do_block(b, WORD, (b == 5) ? 10 : 0, (b == 2) ? 4 : -1, -1);
    chk("full.ch_pulses", ch_cnt, NB - 1);
    repeat (3) @(negedge clk);
    chk("hold.done", prog_done,  1);
    chk("hold.cnt",  block_cnt,  NB - 1);
    chk("hold.en",   master_en,  0);
    chk("hold.din",  master_din, WORD[FB-1]);

    // Restart from DONE, then reset at bit 9 of block 3, then restart from block 0
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int b = 0; b < 3; b++) do_block(b, WORD ^ 18'(b), 0, -1, -1);
    do_block(3, WORD, 0, -1, 9);
    chk("post.busy",  busy,       0);
    chk("post.ready", host_ready, 0);
    chk("post.cnt",   block_cnt,  0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    do_block(0, 18'h3FFFF, 0, -1, -1);
    do_block(1, 18'h00001, 0, -1, -1);

`ifdef CFG_LOADER_PARITY_EN
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    do_block(0, WORD, 0, -1, -1);
    par_flip = 1'b1; host_data = WORD; @(negedge clk); par_flip = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("par.err",  par_err,   1);
      chk("par.done", prog_done, 0);
      chk("par.en",   master_en, 0);
      chk("par.ch",   ch_addr,   0);
      @(negedge clk);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
